// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register file access controller: command
// encodings, controller states and default geometry.
package regfile_ctrl_pkg;

  localparam int DW_DEF = 16;
  localparam int RN_DEF = 16;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_MOVE  = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SWAP2 = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_ctrl_fsm.sv
// Sequencing core of regfile_ctrl: state register, clear counter and
// next-state decode. Datapath decisions live in the top module.
module regfile_ctrl_fsm
  import regfile_ctrl_pkg::*;
#(
  parameter int RN = RN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_fire,
  input  logic [2:0]            op,
  input  logic                  rsp_ready,
  output state_e                state,
  output logic [$clog2(RN)-1:0] cnt
);

  localparam int SW = $clog2(RN);
  localparam logic [SW-1:0] CNT_LAST = SW'(RN - 1);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  state_e        state_r;
  state_e        state_nxt_s;
  logic [SW-1:0] cnt_r;
  logic [SW-1:0] cnt_nxt_s;

  // State and clear-counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_READ:  state_nxt_s = ST_RESP;
          OP_SWAP:  state_nxt_s = ST_SWAP2;
          OP_CLEAR: begin
            state_nxt_s = ST_CLEAR;
            cnt_nxt_s   = {SW{1'b0}};
          end
          default:  state_nxt_s = ST_IDLE;
        endcase
      end
      ST_SWAP2: state_nxt_s = ST_IDLE;
      ST_CLEAR: begin
        // Counter wraps naturally back to 0 on the last step
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {SW{1'b0}};
      end
    endcase
  end

  assign state = state_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: command-driven initiator for a 1W/2R register file.
// Optional build macro REGFILE_CTRL_R0_ZERO_EN makes r0 read as zero and
// suppresses every write aimed at r0.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RN = RN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [$clog2(RN)-1:0] cmd_rd,
  input  logic [$clog2(RN)-1:0] cmd_rs,
  input  logic [$clog2(RN)-1:0] cmd_rt,
  input  logic [DW-1:0]         cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_a,
  output logic [DW-1:0]         rsp_b,
  output logic                  busy,
  input  logic [DW-1:0]         rf_a,
  input  logic [DW-1:0]         rf_b,
  output logic [DW-1:0]         rf_d,
  output logic                  rf_load_en,
  output logic [$clog2(RN)-1:0] rf_dest_sel,
  output logic [$clog2(RN)-1:0] rf_a_sel,
  output logic [$clog2(RN)-1:0] rf_b_sel
);

  localparam int SW = $clog2(RN);

  state_e        state_s;
  logic [SW-1:0] cnt_s;
  logic          cmd_ready_s;
  logic          cmd_fire_s;

  logic [2:0]    op_r;
  logic [SW-1:0] rd_r;
  logic [SW-1:0] rs_r;
  logic [SW-1:0] rt_r;
  logic [DW-1:0] imm_r;
  logic [DW-1:0] tmp_r;
  logic [DW-1:0] rsp_a_r;
  logic [DW-1:0] rsp_b_r;

  logic [DW-1:0] rd_a_s;
  logic [DW-1:0] rd_b_s;
  logic [DW-1:0] rf_d_s;
  logic          load_s;
  logic          load_ok_s;
  logic [SW-1:0] dest_sel_s;
  logic [SW-1:0] a_sel_s;
  logic [SW-1:0] b_sel_s;

  // Held low during reset so nothing is accepted while rst_n is asserted
  assign cmd_ready_s = (state_s == ST_IDLE) && rst_n;
  assign cmd_fire_s  = cmd_valid && cmd_ready_s;

  regfile_ctrl_fsm #(.RN(RN)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_fire  (cmd_fire_s),
    .op        (op_r),
    .rsp_ready (rsp_ready),
    .state     (state_s),
    .cnt       (cnt_s)
  );

  // Latch command fields on acceptance so inputs may change afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r  <= 3'd0;
      rd_r  <= {SW{1'b0}};
      rs_r  <= {SW{1'b0}};
      rt_r  <= {SW{1'b0}};
      imm_r <= {DW{1'b0}};
    end else if (cmd_fire_s) begin
      op_r  <= cmd_op;
      rd_r  <= cmd_rd;
      rs_r  <= cmd_rs;
      rt_r  <= cmd_rt;
      imm_r <= cmd_imm;
    end else begin
      op_r  <= op_r;
      rd_r  <= rd_r;
      rs_r  <= rs_r;
      rt_r  <= rt_r;
      imm_r <= imm_r;
    end
  end

  // Read-port data as seen by the controller (r0 optionally forced to zero)
  always_comb begin
    rd_a_s = rf_a;
    rd_b_s = rf_b;
`ifdef REGFILE_CTRL_R0_ZERO_EN
    if (a_sel_s == {SW{1'b0}}) begin
      rd_a_s = {DW{1'b0}};
    end else begin
      rd_a_s = rf_a;
    end
    if (b_sel_s == {SW{1'b0}}) begin
      rd_b_s = {DW{1'b0}};
    end else begin
      rd_b_s = rf_b;
    end
`endif
  end

  // Per-state register file drive: selects, write data and write strobe
  always_comb begin
    a_sel_s    = {SW{1'b0}};
    b_sel_s    = {SW{1'b0}};
    dest_sel_s = {SW{1'b0}};
    rf_d_s     = {DW{1'b0}};
    load_s     = 1'b0;
    case (state_s)
      ST_EXEC: begin
        a_sel_s = rs_r;
        b_sel_s = rt_r;
        case (op_r)
          OP_WRITE: begin
            rf_d_s = imm_r; dest_sel_s = rd_r; load_s = 1'b1;
          end
          OP_MOVE: begin
            rf_d_s = rd_a_s; dest_sel_s = rd_r; load_s = 1'b1;
          end
          OP_ADD: begin
            rf_d_s = rd_a_s + rd_b_s; dest_sel_s = rd_r; load_s = 1'b1;
          end
          OP_SWAP: begin
            rf_d_s = rd_b_s; dest_sel_s = rs_r; load_s = 1'b1;
          end
          default: load_s = 1'b0;
        endcase
      end
      ST_SWAP2: begin
        rf_d_s = tmp_r; dest_sel_s = rt_r; load_s = 1'b1;
      end
      ST_CLEAR: begin
        rf_d_s = {DW{1'b0}}; dest_sel_s = cnt_s; load_s = 1'b1;
      end
      default: load_s = 1'b0;
    endcase
  end

  // Write qualification: no writes while reset is asserted, optional r0 guard
  always_comb begin
    load_ok_s = load_s && rst_n;
`ifdef REGFILE_CTRL_R0_ZERO_EN
    if (dest_sel_s == {SW{1'b0}}) begin
      load_ok_s = 1'b0;
    end else begin
      load_ok_s = load_s && rst_n;
    end
`endif
  end

  // SWAP holding register and READ response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmp_r   <= {DW{1'b0}};
      rsp_a_r <= {DW{1'b0}};
      rsp_b_r <= {DW{1'b0}};
    end else begin
      if ((state_s == ST_EXEC) && (op_r == OP_SWAP)) begin
        tmp_r <= rd_a_s;
      end else begin
        tmp_r <= tmp_r;
      end
      if ((state_s == ST_EXEC) && (op_r == OP_READ)) begin
        rsp_a_r <= rd_a_s;
        rsp_b_r <= rd_b_s;
      end else begin
        rsp_a_r <= rsp_a_r;
        rsp_b_r <= rsp_b_r;
      end
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign rsp_valid   = (state_s == ST_RESP);
  assign rsp_a       = rsp_a_r;
  assign rsp_b       = rsp_b_r;
  assign busy        = (state_s != ST_IDLE);
  assign rf_d        = rf_d_s;
  assign rf_load_en  = load_ok_s;
  assign rf_dest_sel = dest_sel_s;
  assign rf_a_sel    = a_sel_s;
  assign rf_b_sel    = b_sel_s;

endmodule
